// File: rtl/spmv_row_decoder.sv
// Two-stage CSR row decoder: maps a 1-based nonzero ordinal onto the row that owns it.
// Optional feature macro SPMV_RD_ROWEND_EN adds o_row_last (last nonzero of the row).
module spmv_row_decoder #(
  parameter  int N_ROWS = 16,
  parameter  int PTR_W  = 8,
  localparam int ROW_W  = $clog2(N_ROWS)
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_ptr_load,
  input  logic [(N_ROWS+1)*PTR_W-1:0] i_row_ptr,
  output logic                        o_ptr_err,
  input  logic                        i_cnt_valid,
  output logic                        o_cnt_ready,
  input  logic [PTR_W-1:0]            i_cnt,
  output logic                        o_row_valid,
  input  logic                        i_row_ready,
  output logic [ROW_W-1:0]            o_row,
  output logic                        o_miss,
`ifdef SPMV_RD_ROWEND_EN
  output logic                        o_row_last,
`endif
  output logic                        o_busy
);

  typedef enum logic [1:0] {
    ST_NOTAB = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e              state_r;
  state_e              state_nxt_s;
  logic                tbl_wr_s;
  logic [PTR_W-1:0]    tbl_r [N_ROWS+1];
  logic                ptr_err_r;

  logic                s1_valid_r;
  logic [N_ROWS-1:0]   s1_match_r;
  logic [N_ROWS-1:0]   match_s;
  logic                s2_load_s;
  logic                s1_adv_s;
  logic                pipe_empty_s;
  logic                cnt_ready_s;
  logic                accept_s;

  logic                row_valid_r;
  logic [ROW_W-1:0]    row_r;
  logic                miss_r;
  logic [ROW_W-1:0]    enc_row_s;
  logic                enc_miss_s;

`ifdef SPMV_RD_ROWEND_EN
  logic [N_ROWS-1:0]   s1_last_r;
  logic [N_ROWS-1:0]   last_s;
  logic                enc_last_s;
  logic                row_last_r;
`endif

  // True when any adjacent pointer pair decreases.
  function automatic logic ptr_nonmono(input logic [(N_ROWS+1)*PTR_W-1:0] p);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < N_ROWS; k++) begin
      bad = bad | (p[(k+1)*PTR_W +: PTR_W] < p[k*PTR_W +: PTR_W]);
    end
    return bad;
  endfunction

  assign pipe_empty_s = !s1_valid_r && !row_valid_r;
  assign s2_load_s    = !row_valid_r || i_row_ready;
  assign s1_adv_s     = s1_valid_r && s2_load_s;
  assign cnt_ready_s  = (state_r == ST_RUN) && !i_ptr_load && (!s1_valid_r || s1_adv_s);
  assign accept_s     = i_cnt_valid && cnt_ready_s;

  // Next-state and table-write decision.
  always_comb begin
    state_nxt_s = state_r;
    tbl_wr_s    = 1'b0;
    case (state_r)
      ST_NOTAB: begin
        if (i_ptr_load) begin
          tbl_wr_s    = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_NOTAB;
        end
      end
      ST_RUN: begin
        if (i_ptr_load && pipe_empty_s) begin
          tbl_wr_s    = 1'b1;
          state_nxt_s = ST_RUN;
        end else if (i_ptr_load) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!i_ptr_load) begin
          state_nxt_s = ST_RUN;
        end else if (pipe_empty_s) begin
          tbl_wr_s    = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_NOTAB;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= ST_NOTAB;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pointer table and its monotonicity flag; the table stays in use even when flagged.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int k = 0; k <= N_ROWS; k++) begin
        tbl_r[k] <= {PTR_W{1'b0}};
      end
      ptr_err_r <= 1'b0;
    end else if (tbl_wr_s) begin
      for (int k = 0; k <= N_ROWS; k++) begin
        tbl_r[k] <= i_row_ptr[k*PTR_W +: PTR_W];
      end
      ptr_err_r <= ptr_nonmono(i_row_ptr);
    end
  end

  // Per-row interval match; empty rows fail the strict lower bound automatically.
  always_comb begin
    match_s = {N_ROWS{1'b0}};
`ifdef SPMV_RD_ROWEND_EN
    last_s  = {N_ROWS{1'b0}};
`endif
    for (int k = 0; k < N_ROWS; k++) begin
      match_s[k] = (tbl_r[k] < i_cnt) && (i_cnt <= tbl_r[k+1]);
`ifdef SPMV_RD_ROWEND_EN
      last_s[k]  = (i_cnt == tbl_r[k+1]);
`endif
    end
  end

  // Stage 1: match vector register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_valid_r <= 1'b0;
      s1_match_r <= {N_ROWS{1'b0}};
`ifdef SPMV_RD_ROWEND_EN
      s1_last_r  <= {N_ROWS{1'b0}};
`endif
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_match_r <= match_s;
`ifdef SPMV_RD_ROWEND_EN
      s1_last_r  <= last_s;
`endif
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Highest-index match wins so a non-monotonic table still yields one row.
  always_comb begin
    enc_row_s  = {ROW_W{1'b0}};
    enc_miss_s = 1'b1;
`ifdef SPMV_RD_ROWEND_EN
    enc_last_s = 1'b0;
`endif
    for (int k = 0; k < N_ROWS; k++) begin
      enc_row_s  = s1_match_r[k] ? ROW_W'(k) : enc_row_s;
      enc_miss_s = s1_match_r[k] ? 1'b0 : enc_miss_s;
`ifdef SPMV_RD_ROWEND_EN
      enc_last_s = s1_match_r[k] ? s1_last_r[k] : enc_last_s;
`endif
    end
  end

  // Stage 2: output registers, frozen while the consumer stalls.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      row_valid_r <= 1'b0;
      row_r       <= {ROW_W{1'b0}};
      miss_r      <= 1'b0;
`ifdef SPMV_RD_ROWEND_EN
      row_last_r  <= 1'b0;
`endif
    end else if (s2_load_s) begin
      row_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        row_r      <= enc_row_s;
        miss_r     <= enc_miss_s;
`ifdef SPMV_RD_ROWEND_EN
        row_last_r <= enc_last_s;
`endif
      end
    end
  end

  assign o_ptr_err   = ptr_err_r;
  assign o_cnt_ready = cnt_ready_s;
  assign o_row_valid = row_valid_r;
  assign o_row       = row_r;
  assign o_miss      = miss_r;
  assign o_busy      = s1_valid_r || row_valid_r;
`ifdef SPMV_RD_ROWEND_EN
  assign o_row_last  = row_last_r;
`endif

endmodule
